ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, for example 0xF4 "enable data reporting" or 0xFF "reset", to the mouse over the same open-collector ps2_clk/ps2_data pair the mouse receive path uses. It runs in the 100 MHz domain beside the mouse controller. It drives the lines only through active-high output enables: oe=1 pulls the line low, oe=0 releases it. The top level ties the enables to the inout pads.

## Interface
Parameters:
- INHIBIT_CYC, default 12000: clock-inhibit length in clk cycles (120 µs at 100 MHz).
- TIMEOUT_CYC, default 1500000: maximum gap between device clock falling edges (15 ms).
- GLITCH_LEN, default 4: number of consecutive equal synchronized samples needed to accept a new level on either PS/2 line.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1: system clock, 100 MHz.
- rst  in  1: synchronous, active-high reset.
- tx_data  in  8: command byte.
- tx_valid  in  1: request to send tx_data.
- tx_ready  out  1: block is idle and will accept tx_valid.
- tx_done  out  1: one-cycle pulse when a transfer ends.
- tx_err  out  1: qualifies tx_done. 1 = no ACK or timeout. 0 whenever tx_done=0.
- ps2_clk_in  in  1: raw ps2_clk pad level.
- ps2_data_in  in  1: raw ps2_data pad level.
- ps2_clk_oe  out  1: 1 pulls ps2_clk low.
- ps2_data_oe  out  1: 1 pulls ps2_data low.

## Operation
Input conditioning:
- Each line passes through a 2-FF synchronizer, then a glitch filter. The filtered level changes only after GLITCH_LEN consecutive identical synchronized samples.
- fall_clk is a one-cycle pulse on each 1→0 transition of the filtered clock.

States:
- IDLE: tx_ready=1, both oe=0. On tx_valid=1: latch tx_data, compute par = ~^tx_data (odd parity), clear bit counter k=0, go to INHIBIT.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles, then go to RTS.
- RTS: ps2_clk_oe=1 and ps2_data_oe=1 for 1 cycle. This is the start bit, data low. Go to SEND, clear the timeout counter.
- SEND: ps2_clk_oe=0. On each fall_clk, increment k and update the data line:
  - k=1..8: ps2_data_oe <= ~tx_data[k-1] (LSB first).
  - k=9: ps2_data_oe <= ~par.
  - k=10: ps2_data_oe <= 0 (stop bit, line released). Go to ACK.
- ACK: on the next fall_clk (edge 11), sample the filtered data line. 0 → ack_ok=1; 1 → ack_ok=0. Go to WAIT_IDLE.
- WAIT_IDLE: wait until both filtered lines are 1. Then pulse tx_done=1 with tx_err=~ack_ok and go to IDLE.

Timeout and reset:
- In SEND, ACK and WAIT_IDLE the timeout counter clears on every fall_clk.
- When it reaches TIMEOUT_CYC: release both oe, pulse tx_done=1 with tx_err=1, go to IDLE.
- Reset values: state=IDLE, tx_ready=1, tx_done=0, tx_err=0, ps2_clk_oe=0, ps2_data_oe=0, counters 0. Synchronizer and filter flops are set to 1 (lines idle high).
- Reset mid-transfer: both lines are released on the first clk edge with rst=1. No tx_done is produced.

Boundary conditions:
- tx_valid while tx_ready=0 is ignored and not queued.
- tx_valid in the same cycle as a tx_done pulse is ignored, because tx_ready is still 0 in that cycle.
- Device clock activity during INHIBIT or RTS is ignored.

## Timing
- Acceptance cycle T (tx_valid & tx_ready): at T+1, tx_ready=0 and ps2_clk_oe=1.
- Clock release: ps2_clk_oe=1 for INHIBIT_CYC+1 cycles in total; ps2_data_oe rises in the last of those cycles.
- Filter latency: a pad transition reaches the filtered line GLITCH_LEN+2 cycles later. fall_clk asserts in that cycle, and ps2_data_oe updates on the following clk edge.
- ACK sampling happens in the fall_clk cycle of edge 11.
- tx_ready returns to 1 the cycle after the tx_done pulse.
- All outputs are registered.

## Test plan
Simulation parameters: INHIBIT_CYC=20, TIMEOUT_CYC=2000, GLITCH_LEN=2. The device model clocks with a 40-cycle period and samples data on rising edges.

1. Send 0xF4 with the device ACKing.
   - Device samples start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
   - ps2_clk_oe is high for 21 cycles after acceptance.
   - Expect tx_done=1 with tx_err=0, then tx_ready=1.
2. Send 0x00.
   - Expect parity bit 1, stop bit 1, tx_err=0.
   - Send 0xFF back-to-back after tx_ready: expect parity 1.
3. Device leaves data high at edge 11 (no ACK).
   - Expect tx_done with tx_err=1 once both lines are high.
4. Device never clocks after the clock release.
   - Expect tx_done with tx_err=1 exactly 2000 cycles after the SEND entry, both oe=0.
5. Inject a 1-cycle low glitch on ps2_clk_in during SEND.
   - Expect no bit advance: the byte is still received intact and tx_err=0.
   - Assert tx_valid mid-transfer: expect it to be ignored, with no second transfer.
6. Assert rst at edge 5 of SEND.
   - Expect both oe=0 on the next clk edge and no tx_done.
   - After rst deasserts, tx_ready=1 and a new 0xF4 transfer completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device over the open-collector
// ps2_clk/ps2_data pair. The sequence is:
//   1. Inhibit the clock.
//   2. Request-to-send: pull data low, then release the clock.
//   3. Shift out 8 data bits LSB first, then odd parity, then the stop bit,
//      one bit per device clock fall.
//   4. Sample the device ACK on clock edge 11.
//   5. Wait for both lines to return high.
// Ports:
//   clk, rst        100 MHz clock, synchronous active-high reset
//   tx_data/valid   command byte and send request (taken only while tx_ready)
//   tx_ready        idle, will accept tx_valid
//   tx_done/tx_err  one-cycle end-of-transfer pulse; tx_err=1 -> no ACK or timeout
//   ps2_*_in        raw pad levels
//   ps2_*_oe        active-high pull-low enables for the pads
module ps2_host_tx #(
   parameter int INHIBIT_CYC = 12000,
   parameter int TIMEOUT_CYC = 1500000,
   parameter int GLITCH_LEN  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int TMAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int GW   = $clog2(GLITCH_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
   } state_t;

   // ---------------------------------------------------------------
   // Input conditioning. Index 0 is the clock line; index 1 is the data line.
   // ---------------------------------------------------------------
   logic [1:0]         s1, s2, filt;
   logic [1:0][GW-1:0] gcnt;
   logic               fall_clk;
   logic               clk_f, data_f;

   assign clk_f  = filt[0];
   assign data_f = filt[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= '1;
         s2       <= '1;
         filt     <= '1;
         gcnt     <= '0;
         fall_clk <= 1'b0;
      end else begin
         s1 <= {ps2_data_in, ps2_clk_in};
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            // gcnt counts samples that disagree with the filtered level.
            // The level flips on the GLITCH_LEN-th consecutive disagreement.
            if (s2[i] == filt[i]) begin
               gcnt[i] <= '0;
            end else if (gcnt[i] == GW'(GLITCH_LEN - 1)) begin
               filt[i] <= s2[i];
               gcnt[i] <= '0;
            end else begin
               gcnt[i] <= gcnt[i] + 1'b1;
            end
         end
         // Registered so the pulse lines up with the cycle in which
         // filt[0] first reads 0.
         fall_clk <= filt[0] & ~s2[0] & (gcnt[0] == GW'(GLITCH_LEN - 1));
      end
   end

   // ---------------------------------------------------------------
   // Transfer FSM. Every output is a register loaded from its _n value.
   // ---------------------------------------------------------------
   state_t          state, state_n;
   logic [7:0]      data_q, data_n;
   logic            par, par_n;
   logic [3:0]      k, k_n;
   logic [TW-1:0]   tmr, tmr_n;
   logic            ack_ok, ack_n;
   logic            ready_n, done_n, err_n, clk_oe_n, data_oe_n;
   logic            to_hit;

   assign to_hit = (tmr == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         data_q      <= '0;
         par         <= 1'b0;
         k           <= '0;
         tmr         <= '0;
         ack_ok      <= 1'b0;
         tx_ready    <= 1'b1;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         state       <= state_n;
         data_q      <= data_n;
         par         <= par_n;
         k           <= k_n;
         tmr         <= tmr_n;
         ack_ok      <= ack_n;
         tx_ready    <= ready_n;
         tx_done     <= done_n;
         tx_err      <= err_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
      end
   end

   always_comb begin
      state_n   = state;
      data_n    = data_q;
      par_n     = par;
      k_n       = k;
      tmr_n     = tmr;
      ack_n     = ack_ok;
      done_n    = 1'b0;
      err_n     = 1'b0;
      clk_oe_n  = 1'b0;
      data_oe_n = ps2_data_oe;

      case (state)
         S_IDLE: begin
            data_oe_n = 1'b0;
            tmr_n     = '0;
            if (tx_valid && tx_ready) begin
               data_n   = tx_data;
               par_n    = ~^tx_data;
               k_n      = '0;
               clk_oe_n = 1'b1;
               state_n  = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            clk_oe_n = 1'b1;
            if (tmr == TW'(INHIBIT_CYC - 1)) begin
               tmr_n     = '0;
               data_oe_n = 1'b1;  // start bit goes out with the last inhibit cycle
               state_n   = S_RTS;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end

         S_RTS: begin
            data_oe_n = 1'b1;
            tmr_n     = '0;
            state_n   = S_SEND;
         end

         S_SEND: begin
            if (fall_clk) begin
               tmr_n = '0;
               k_n   = k + 1'b1;
               // k holds the count before this edge.
               if (k < 4'd8) begin
                  data_oe_n = ~data_q[k[2:0]];
               end else if (k == 4'd8) begin
                  data_oe_n = ~par;
               end else begin
                  data_oe_n = 1'b0;  // stop bit: line released
                  state_n   = S_ACK;
               end
            end else if (to_hit) begin
               data_oe_n = 1'b0;
               done_n    = 1'b1;
               err_n     = 1'b1;
               tmr_n     = '0;
               state_n   = S_IDLE;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end

         S_ACK: begin
            if (fall_clk) begin
               tmr_n   = '0;
               ack_n   = ~data_f;
               state_n = S_WAIT_IDLE;
            end else if (to_hit) begin
               data_oe_n = 1'b0;
               done_n    = 1'b1;
               err_n     = 1'b1;
               tmr_n     = '0;
               state_n   = S_IDLE;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end

         S_WAIT_IDLE: begin
            if (clk_f && data_f) begin
               done_n  = 1'b1;
               err_n   = ~ack_ok;
               tmr_n   = '0;
               state_n = S_IDLE;
            end else if (fall_clk) begin
               tmr_n = '0;
            end else if (to_hit) begin
               data_oe_n = 1'b0;
               done_n    = 1'b1;
               err_n     = 1'b1;
               tmr_n     = '0;
               state_n   = S_IDLE;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end

         default: begin
            data_oe_n = 1'b0;
            state_n   = S_IDLE;
         end
      endcase

      // tx_ready is held low through the tx_done cycle, so a request in
      // that cycle is not taken.
      ready_n = (state_n == S_IDLE) && !done_n;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx. A behavioural PS/2 device clocks
// with a 40-cycle period, samples data on its rising edges and optionally
// ACKs. Table-driven transfers come first. Hand-written sequences then
// cover timeout, a clock glitch, a mid-transfer request and a
// mid-transfer reset.
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int TO  = 2000;
   localparam int GL  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk = 1'b1, dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;

   // Open-collector wiring: either side can pull a line low.
   assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .GLITCH_LEN(GL)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge.
   int         done_cnt = 0, clk_oe_cnt = 0, both_cnt = 0, stray_err = 0;
   int         both_cyc = -1, done_cyc = -1;
   logic       done_err = 1'b0, done_rdy = 1'b0, rdy_after = 1'b0, prev_done = 1'b0;
   logic [1:0] done_oe = 2'b00;

   always @(negedge clk) begin
      if (prev_done) rdy_after = tx_ready;
      prev_done = tx_done;
      if (tx_done) begin
         done_cnt = done_cnt + 1;
         done_err = tx_err;
         done_cyc = cyc;
         done_rdy = tx_ready;
         done_oe  = {ps2_clk_oe, ps2_data_oe};
      end
      if (tx_err && !tx_done) stray_err = stray_err + 1;
      if (ps2_clk_oe) clk_oe_cnt = clk_oe_cnt + 1;
      if (ps2_clk_oe && ps2_data_oe) begin
         both_cnt = both_cnt + 1;
         both_cyc = cyc;
      end
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, output int t);
      int n = 0;
      while (tx_ready !== 1'b1 && n < 500) begin
         step(1);
         n++;
      end
      chk("send_ready", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      t        = cyc;
      step(1);
      tx_valid = 1'b0;
      chk("accept_ready_low", tx_ready, 0);
      chk("accept_clk_oe", ps2_clk_oe, 1);
   endtask

   task automatic wait_done(input int base, input int lim);
      int n = 0;
      while (done_cnt <= base && n < lim) begin
         step(1);
         n++;
      end
      chk("done_seen", done_cnt > base, 1);
      @(negedge clk);
      #1;
   endtask

   // Device side of one transfer. glitch_e/rst_e select the clock edge at
   // which a glitch (plus a stray tx_valid) or a host reset is injected.
   task automatic dev_xfer(input bit ack, input int glitch_e, input int rst_e,
                           output logic [10:0] fr);
      int n = 0;
      fr = '0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_in === 1'b0) && n < 200) begin
         step(1);
         n++;
      end
      chk("dev_request_seen", n < 200, 1);
      if (n >= 200) return;
      step(10);
      fr[0] = ps2_data_in;
      for (int e = 1; e <= 10; e++) begin
         dev_clk = 1'b0;
         step(10);
         if (e == rst_e) begin
            chk("pre_rst_data_oe", ps2_data_oe, 1);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rst_releases_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            return;
         end
         step(10);
         dev_clk = 1'b1;
         fr[e]   = ps2_data_in;
         if (e == glitch_e) begin
            step(8);
            dev_clk = 1'b0;
            step(1);
            dev_clk  = 1'b1;
            tx_data  = 8'h11;
            tx_valid = 1'b1;
            step(1);
            tx_valid = 1'b0;
            step(10);
         end else begin
            step(10);
            if (e == 10 && ack) dev_data = 1'b0;
            step(10);
         end
      end
      dev_clk = 1'b0;  // edge 11: host samples ACK
      step(20);
      dev_clk = 1'b1;
      step(10);
      dev_data = 1'b1;
   endtask

   typedef struct {
      logic [7:0]  d;
      bit          ack;
      bit          exp_err;
      logic [10:0] exp_fr;  // {stop, parity, data[7:0], start}
   } vec_t;

   vec_t vecs[4];

   task automatic run_vec(input vec_t v, input int idx);
      int b_done, b_clk, b_both, t;
      logic [10:0] fr;
      b_done = done_cnt;
      b_clk  = clk_oe_cnt;
      b_both = both_cnt;
      send(v.d, t);
      dev_xfer(v.ack, 0, 0, fr);
      wait_done(b_done, 400);
      chk($sformatf("v%0d_frame", idx), fr, v.exp_fr);
      chk($sformatf("v%0d_err", idx), done_err, v.exp_err);
      chk($sformatf("v%0d_done_count", idx), done_cnt - b_done, 1);
      chk($sformatf("v%0d_ready_in_done", idx), done_rdy, 0);
      chk($sformatf("v%0d_ready_after", idx), rdy_after, 1);
      chk($sformatf("v%0d_clk_oe_cycles", idx), clk_oe_cnt - b_clk, INH + 1);
      chk($sformatf("v%0d_rts_cycles", idx), both_cnt - b_both, 1);
      chk($sformatf("v%0d_rts_position", idx), both_cyc - t, INH + 1);
   endtask

   initial begin
      int b_done, b_clk, t;
      logic [10:0] fr;

      vecs[0] = '{8'hF4, 1'b1, 1'b0, {1'b1, 1'b0, 8'hF4, 1'b0}};
      vecs[1] = '{8'h00, 1'b1, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}};
      vecs[3] = '{8'h5A, 1'b0, 1'b1, {1'b1, 1'b1, 8'h5A, 1'b0}};

      step(3);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_tx_done", tx_done, 0);
      chk("rst_tx_err", tx_err, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      rst = 1'b0;
      step(10);

      // ACKed transfers back to back, then a transfer with no ACK.
      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
      step(20);

      // Device never clocks: timeout after TO cycles in SEND.
      b_done = done_cnt;
      send(8'hA5, t);
      wait_done(b_done, TO + 500);
      chk("timeout_err", done_err, 1);
      chk("timeout_oe", done_oe, 2'b00);
      chk("timeout_latency", done_cyc - t, INH + 2 + TO);
      chk("timeout_ready_after", rdy_after, 1);
      step(20);

      // Clock glitch plus stray tx_valid mid-transfer.
      b_done = done_cnt;
      b_clk  = clk_oe_cnt;
      send(8'hF4, t);
      dev_xfer(1'b1, 3, 0, fr);
      wait_done(b_done, 400);
      chk("glitch_frame", fr, {1'b1, 1'b0, 8'hF4, 1'b0});
      chk("glitch_err", done_err, 0);
      step(100);
      chk("glitch_one_done", done_cnt - b_done, 1);
      chk("glitch_no_second_xfer", clk_oe_cnt - b_clk, INH + 1);

      // Reset at edge 5 of SEND.
      b_done = done_cnt;
      send(8'h00, t);
      dev_xfer(1'b1, 0, 5, fr);
      step(3);
      rst = 1'b0;
      step(50);
      chk("rst_mid_no_done", done_cnt - b_done, 0);
      chk("rst_mid_ready", tx_ready, 1);
      run_vec(vecs[0], 4);

      chk("no_stray_err", stray_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
